// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the single-port memory bus arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Wide enough for any data width up to 512 bits; users slice the low bits.
  localparam int unsigned                STRB_MAX   = 64;
  localparam logic [STRB_MAX-1:0] INST_WSTRB = {STRB_MAX{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA_ADDR = 3'd1,
    ST_DATA_WAIT = 3'd2,
    ST_INST_ADDR = 3'd3,
    ST_INST_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arbiter_ibuf.sv
// One-entry instruction buffer (valid, word address, data) for the arbiter.
// Only instantiated when MEM_ARBITER_IBUF_EN is defined.
module mem_arbiter_ibuf
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic              i_inv,
  input  logic [ADDR_W-3:0] i_bus_word,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_req,
  input  logic [ADDR_W-3:0] i_word,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-3:0] r_word;
  logic [DATA_W-1:0] r_data;

  // Buffer fill on fetch completion; a store to the buffered word invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_word  <= i_bus_word;
      r_data  <= i_fill_data;
    end else if (i_inv && r_valid && (i_bus_word == r_word)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = i_req & r_valid & (i_word == r_word);
  assign o_data = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data access onto one SRAM-style bus.
// Define MEM_ARBITER_IBUF_EN to add a one-entry instruction buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_stall,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                stallreq_from_if,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                stallreq_from_mem,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_e            r_state;
  logic              r_inst_done;
  logic              r_data_done;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_bus_req;
  logic              r_bus_wr;
  logic [STRB_W-1:0] r_bus_wstrb;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;

  logic w_ibuf_hit;
  logic w_inst_pend;
  logic w_data_pend;

`ifdef MEM_ARBITER_IBUF_EN
  logic              w_ibuf_fill;
  logic              w_ibuf_inv;
  logic [DATA_W-1:0] w_ibuf_data;

  assign w_ibuf_fill = (r_state == ST_INST_WAIT) & bus_data_ok;
  assign w_ibuf_inv  = (r_state == ST_DATA_ADDR) & bus_addr_ok & r_bus_wr;

  mem_arbiter_ibuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .i_fill     (w_ibuf_fill),
    .i_inv      (w_ibuf_inv),
    .i_bus_word (r_bus_addr[ADDR_W-1:2]),
    .i_fill_data(bus_rdata),
    .i_req      (inst_req),
    .i_word     (inst_addr[ADDR_W-1:2]),
    .o_hit      (w_ibuf_hit),
    .o_data     (w_ibuf_data)
  );

  assign inst_rdata = w_ibuf_hit ? w_ibuf_data : r_inst_rdata;
`else
  assign w_ibuf_hit = 1'b0;
  assign inst_rdata = r_inst_rdata;
`endif

  assign w_inst_pend       = inst_req & ~r_inst_done & ~w_ibuf_hit;
  assign w_data_pend       = data_req & ~r_data_done;
  assign stallreq_from_if  = w_inst_pend;
  assign stallreq_from_mem = w_data_pend;

  assign data_rdata = r_data_rdata;
  assign bus_req    = r_bus_req;
  assign bus_wr     = r_bus_wr;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;

  // Arbiter FSM with registered bus outputs, done flags and response latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_bus_req    <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_bus_wstrb  <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
    end else begin
      // An advancing edge clears both flags; a completion below overrides its own.
      if (!cpu_stall) begin
        r_inst_done <= 1'b0;
        r_data_done <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_data_pend) begin
            r_state     <= ST_DATA_ADDR;
            r_bus_req   <= 1'b1;
            r_bus_wr    <= data_wr;
            r_bus_wstrb <= data_sel;
            r_bus_addr  <= data_addr;
            r_bus_wdata <= data_wdata;
          end else if (w_inst_pend) begin
            r_state     <= ST_INST_ADDR;
            r_bus_req   <= 1'b1;
            r_bus_wr    <= 1'b0;
            r_bus_wstrb <= INST_WSTRB[STRB_W-1:0];
            r_bus_addr  <= inst_addr;
            r_bus_wdata <= '0;
          end
        end
        ST_DATA_ADDR: begin
          if (bus_addr_ok) begin
            r_state   <= ST_DATA_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        ST_DATA_WAIT: begin
          if (bus_data_ok) begin
            r_data_done <= 1'b1;
            if (!r_bus_wr) begin
              r_data_rdata <= bus_rdata;
            end
            if (w_inst_pend) begin
              r_state     <= ST_INST_ADDR;
              r_bus_req   <= 1'b1;
              r_bus_wr    <= 1'b0;
              r_bus_wstrb <= INST_WSTRB[STRB_W-1:0];
              r_bus_addr  <= inst_addr;
              r_bus_wdata <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_INST_ADDR: begin
          if (bus_addr_ok) begin
            r_state   <= ST_INST_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        ST_INST_WAIT: begin
          if (bus_data_ok) begin
            r_inst_rdata <= bus_rdata;
            r_inst_done  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random CPU steps against a word-level
// memory model, a randomly delayed bus slave, plus directed corner cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        stallreq_from_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stallreq_from_mem;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic        sl_dok = 1'b0;
  logic        stale_dok = 1'b0;
  logic [31:0] sl_rdata = 32'h0;
  logic [31:0] stale_rdata = 32'h0;
  assign bus_data_ok = sl_dok | stale_dok;
  assign bus_rdata   = stale_dok ? stale_rdata : sl_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .stallreq_from_if(stallreq_from_if),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .stallreq_from_mem(stallreq_from_mem),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Word-level memories: the CPU's intended view and what the slave really holds.
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : init_word({a[31:2], 2'b00});
  endfunction

  // ---------------- bus slave ----------------
  int          sl_phase = 0;
  int          sl_cnt = 0;
  bit          sl_fresh = 1'b0;
  int          sl_adly_fix = -1;
  int          sl_ddly_fix = -1;
  int          breq_cycles = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_wr;
  logic [3:0]  cap_strb;
  logic [31:0] log_addr[$];
  logic [3:0]  log_strb[$];

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  initial bus_addr_ok = 1'b0;

  always @(negedge clk) begin
    bus_addr_ok = 1'b0;
    sl_dok      = 1'b0;
    if (bus_req) breq_cycles++;
    if (rst) begin
      sl_phase = 0;
    end else begin
      if (sl_phase == 0 && bus_req) begin
        sl_phase  = 1;
        sl_fresh  = 1'b1;
        sl_cnt    = pick(sl_adly_fix);
        cap_addr  = bus_addr;
        cap_wr    = bus_wr;
        cap_strb  = bus_wstrb;
        cap_wdata = bus_wdata;
      end
      if (sl_phase == 1) begin
        if (!sl_fresh)
          check("bus_hold", {31'd0, (bus_req === 1'b1) && (bus_addr === cap_addr) &&
                (bus_wr === cap_wr) && (bus_wstrb === cap_strb) && (bus_wdata === cap_wdata)}, 32'd1);
        sl_fresh = 1'b0;
        if (sl_cnt == 0) begin
          bus_addr_ok = 1'b1;
          log_addr.push_back(cap_addr);
          log_strb.push_back(cap_strb);
          sl_phase = 2;
          sl_cnt   = pick(sl_ddly_fix);
        end else begin
          sl_cnt--;
        end
      end else if (sl_phase == 2) begin
        if (sl_cnt == 0) begin
          sl_dok = 1'b1;
          if (cap_wr) begin
            slv_mem[cap_addr[31:2]] = merge(slv_rd(cap_addr), cap_wdata, cap_strb);
            sl_rdata = $urandom;
          end else begin
            sl_rdata = slv_rd(cap_addr);
          end
          sl_phase = 0;
        end else begin
          sl_cnt--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] q_inst[$];
  logic [31:0] q_data[$];
  bit          sb_en = 1'b1;
  bit          mi_seen = 1'b0;
  bit          md_seen = 1'b0;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (inst_req && !stallreq_from_if && !mi_seen) begin
        mi_seen = 1'b1;
        if (q_inst.size() == 0) check("inst_unexpected", 32'd1, 32'd0);
        else check("inst_rdata", inst_rdata, q_inst.pop_front());
      end
      if (data_req && !stallreq_from_mem && !md_seen) begin
        md_seen = 1'b1;
        if (q_data.size() == 0) check("data_unexpected", 32'd1, 32'd0);
        else check("data_rdata", data_rdata, q_data.pop_front());
      end
      if (!cpu_stall) begin
        mi_seen = 1'b0;
        md_seen = 1'b0;
      end
    end
  end

  // ---------------- CPU driver / reference model ----------------
  logic [31:0] last_load = 32'h0;

  // Called at posedge+1; returns at posedge+1 right after the advancing edge.
  task automatic do_step(input logic ireq, input logic [31:0] ia, input logic dreq,
                         input logic dwr, input logic [3:0] dsel, input logic [31:0] da,
                         input logic [31:0] dwd, input int hold, output int mfall,
                         output int ifall, output logic stall0, output int nbreq);
    int cyc;
    int b0;
    logic [31:0] ei;
    b0 = breq_cycles;
    ei = 32'h0;
    inst_req = ireq; inst_addr = ia;
    data_req = dreq; data_wr = dwr; data_sel = dsel; data_addr = da; data_wdata = dwd;
    cpu_stall = 1'b1;
    if (dreq) begin
      if (dwr) ref_mem[da[31:2]] = merge(ref_rd(da), dwd, dsel);
      else last_load = ref_rd(da);
      q_data.push_back(last_load);
    end
    if (ireq) begin
      ei = ref_rd(ia);
      q_inst.push_back(ei);
    end
    #1;
    stall0 = stallreq_from_if;
    cyc = 0; mfall = -1; ifall = -1;
    forever begin
      if (!stallreq_from_mem && mfall < 0) mfall = cyc;
      if (!stallreq_from_if && ifall < 0) ifall = cyc;
      if (!stallreq_from_if && !stallreq_from_mem) break;
      if (cyc >= 100) begin
        check("step_timeout", 32'(cyc), 32'd100 - 32'd1);
        break;
      end
      @(posedge clk); #2;
      cyc++;
    end
    repeat (hold) begin
      @(posedge clk); #2;
      check("hold_if", {31'd0, stallreq_from_if}, 32'd0);
      check("hold_mem", {31'd0, stallreq_from_mem}, 32'd0);
      if (ireq) check("hold_irdata", inst_rdata, ei);
      if (dreq) check("hold_drdata", data_rdata, last_load);
    end
    nbreq = breq_cycles - b0;
    cpu_stall = 1'b0;
    @(posedge clk); #1;
    cpu_stall = 1'b1;
    inst_req  = 1'b0;
    data_req  = 1'b0;
  endtask

  initial begin
    int mf, ifl, nb, n0, hold;
    logic s0, ir, dr, dw;
    logic [3:0] ds;
    logic [31:0] ia, da, dwd;

    rst = 1'b1; cpu_stall = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_sel = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    ref_mem[30'h2FF0_0000] = 32'h2408_0001;  slv_mem[30'h2FF0_0000] = 32'h2408_0001;
    ref_mem[30'h2000_0008] = 32'h1234_5678;  slv_mem[30'h2000_0008] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_stalls", {30'd0, stallreq_from_if, stallreq_from_mem}, 32'd0);
    @(posedge clk); #1;

    // Fetch only, fastest slave.
    sl_adly_fix = 0; sl_ddly_fix = 0;
    do_step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, mf, ifl, s0, nb);
    check("fetch_if_fall", 32'(ifl), 32'd3);
    check("fetch_breq_cycles", 32'(nb), 32'd1);

    // Simultaneous store + fetch: store goes first.
    n0 = log_addr.size();
    do_step(1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 0, mf, ifl, s0, nb);
    check("simul_mem_fall", 32'(mf), 32'd3);
    check("simul_if_fall", 32'(ifl), 32'd5);
    check("simul_first_addr", log_addr[n0], 32'h8000_0010);
    check("simul_first_strb", {28'd0, log_strb[n0]}, 32'h3);
    check("simul_second_addr", log_addr[n0+1], 32'hBFC0_0004);
    check("simul_second_strb", {28'd0, log_strb[n0+1]}, 32'hF);

    // Slow slave: address accept delayed three cycles, result held while stalled.
    sl_adly_fix = 3;
    do_step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8000_0020, 32'h0, 3, mf, ifl, s0, nb);
    check("slow_mem_fall", 32'(mf), 32'd6);
    do_step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 0, mf, ifl, s0, nb);
    sl_adly_fix = 0;

    // Done flag holds through a stall, then re-arms after the advancing edge.
    do_step(1'b1, 32'hBFC0_0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5, mf, ifl, s0, nb);
    check("hold_no_reissue", 32'(nb), 32'd1);
    do_step(1'b1, 32'hBFC0_0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, mf, ifl, s0, nb);
`ifdef MEM_ARBITER_IBUF_EN
    check("rearm_stall_if", {31'd0, s0}, 32'd0);
`else
    check("rearm_stall_if", {31'd0, s0}, 32'd1);
`endif

    // Reset while the load is waiting for data.
    sb_en = 1'b0; sl_ddly_fix = 3;
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'hF; data_addr = 32'h8000_0020;
    data_wdata = 32'h5555_AAAA;
    n0 = 0;
    while (n0 < 20) begin
      @(posedge clk); #2;
      n0++;
      if (sl_phase == 2) break;
    end
    check("rst_reach_wait", {31'd0, sl_phase == 2}, 32'd1);
    rst = 1'b1; data_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("midrst_bus_req", {31'd0, bus_req}, 32'd0);
    check("midrst_bus_addr", bus_addr, 32'd0);
    check("midrst_bus_ctl", {27'd0, bus_wr, bus_wstrb}, 32'd0);
    check("midrst_bus_wdata", bus_wdata, 32'd0);
    check("midrst_rdata", inst_rdata | data_rdata, 32'd0);
    last_load = 32'h0;
    stale_rdata = 32'hDEAD_BEEF; stale_dok = 1'b1;
    @(posedge clk); #1 stale_dok = 1'b0;
    @(posedge clk); #1;
    check("stale_data_rdata", data_rdata, 32'd0);
    check("stale_inst_rdata", inst_rdata, 32'd0);
    check("stale_bus_req", {31'd0, bus_req}, 32'd0);
    sb_en = 1'b1; sl_adly_fix = -1; sl_ddly_fix = -1;

`ifdef MEM_ARBITER_IBUF_EN
    do_step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, mf, ifl, s0, nb);
    check("ibuf_cold_breq", 32'(nb), 32'd1);
    do_step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, mf, ifl, s0, nb);
    check("ibuf_hit_breq", 32'(nb), 32'd0);
    check("ibuf_hit_stall", {31'd0, s0}, 32'd0);
    do_step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'hBFC0_0000, 32'h1111_2222, 0, mf, ifl, s0, nb);
    do_step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, mf, ifl, s0, nb);
    check("ibuf_inval_breq", 32'(nb), 32'd1);
`endif

    // Random traffic; instruction and data regions kept disjoint.
    for (int n = 0; n < 200; n++) begin
      ir   = ($urandom_range(0, 3) != 0);
      ia   = 32'hBFC0_0000 + 32'($urandom_range(0, 7) * 4);
      dr   = 1'($urandom_range(0, 1));
      dw   = 1'($urandom_range(0, 1));
      ds   = 4'($urandom_range(1, 15));
      da   = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
      dwd  = $urandom;
      hold = int'($urandom_range(0, 2));
      do_step(ir, ia, dr, dw, ds, da, dwd, hold, mf, ifl, s0, nb);
    end

    check("sb_inst_drained", 32'(q_inst.size()), 32'd0);
    check("sb_data_drained", 32'(q_data.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory bus arbiter between instruction fetch and data access. Serialises the IF-stage fetch (`pcF`) and the MEM-stage load/store (`aluoutM`, `writedataM`, `ls_selM2`) onto one SRAM-style bus with at most one outstanding transaction. Latches each response and drives `stallreq_from_if` / `stallreq_from_mem` into the hazard unit, so the pipeline advances only when both sides of the current cycle are satisfied.

## Interface
- `ADDR_W`, default 32: bus and CPU address width.
- `DATA_W`, default 32: data width; the byte strobe is `DATA_W/8` bits.

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_stall` input 1: global pipeline stall. Low means the pipeline advances at this edge.
- `inst_req` input 1: fetch wanted this cycle.
- `inst_addr` input ADDR_W: fetch address (`pcF`).
- `inst_rdata` output DATA_W: fetched word, held.
- `stallreq_from_if` output 1: fetch not yet satisfied.
- `data_req` input 1: load/store wanted; equals `|ls_selM2`.
- `data_wr` input 1: 1 means store.
- `data_sel` input DATA_W/8: byte strobe (`ls_selM2`).
- `data_addr` input ADDR_W: effective address.
- `data_wdata` input DATA_W: store data.
- `data_rdata` output DATA_W: load word, held.
- `stallreq_from_mem` output 1: data access not yet satisfied.
- `bus_req` output 1: transaction request.
- `bus_wr` output 1: write transaction.
- `bus_wstrb` output DATA_W/8: byte strobe. All ones on instruction reads.
- `bus_addr` output ADDR_W: transaction address.
- `bus_wdata` output DATA_W: write data.
- `bus_addr_ok` input 1: request accepted.
- `bus_data_ok` input 1: transaction complete.
- `bus_rdata` input DATA_W: read data, valid with `bus_data_ok`.

## Operation
- FSM states: IDLE, DATA_ADDR, DATA_WAIT, INST_ADDR, INST_WAIT.
- **IDLE**
  - Pending data (`data_req & ~data_done`) goes to DATA_ADDR.
  - Otherwise, pending fetch (`inst_req & ~inst_done`) goes to INST_ADDR.
  - Data has priority because it belongs to the older instruction.
- **DATA_ADDR / INST_ADDR**
  - `bus_req=1`.
  - `bus_addr`, `bus_wr`, `bus_wstrb`, `bus_wdata` come from registers captured on state entry.
  - They must stay stable until `bus_addr_ok`.
  - On `bus_addr_ok`, move to the matching WAIT state.
- **DATA_WAIT / INST_WAIT**
  - `bus_req=0`.
  - On `bus_data_ok`:
    - DATA_WAIT sets `data_done`; a read also latches `data_rdata <= bus_rdata`.
    - INST_WAIT latches `inst_rdata` and sets `inst_done`.
  - Next state: INST_ADDR if data just finished and a fetch is still pending; otherwise IDLE.
- **Stall outputs** are combinational:
  - `stallreq_from_if = inst_req & ~inst_done`
  - `stallreq_from_mem = data_req & ~data_done`
- **Done flags**: any edge with `cpu_stall=0` clears both `inst_done` and `data_done`. A `bus_data_ok` in the same edge wins for its own flag.
- **Store completion**: a store sets `data_done` on `bus_data_ok`; `data_rdata` is unchanged.
- **Reset**
  - State goes to IDLE; both done flags to 0.
  - Outputs reset to zero: `inst_rdata`, `data_rdata`, `bus_req`, `bus_wr`, `bus_wstrb`, `bus_addr`, `bus_wdata`.
  - Reset mid-transaction abandons the transaction; the bus slave is reset by the same `rst`.
- **Dropped requests**: a request that falls while its transaction is in flight still completes. Its done flag is cleared by the next advancing edge.

## Timing
- Best case is 2 cycles request-to-done: request seen in IDLE at cycle 0, `bus_req` at cycle 1 with `bus_addr_ok`, `bus_data_ok` at cycle 2. The done flag is visible from cycle 3.
- Data + fetch in the same cycle takes at least 4 cycles; the fetch issues in the cycle after the data `bus_data_ok`.
- `bus_data_ok` is ignored outside the WAIT states. `bus_addr_ok` is ignored outside the ADDR states.

## Configuration
- Macro: `MEM_ARBITER_IBUF_EN`.
- **Defined**: a one-entry instruction buffer holding (valid, word address, data), filled on every INST_WAIT `bus_data_ok`.
  - On a hit (`inst_req`, valid, `inst_addr[ADDR_W-1:2]` matches):
    - `stallreq_from_if` is 0 in the same cycle;
    - `inst_rdata` shows the buffer data;
    - no bus transaction is issued.
  - Invalidation:
    - any DATA_ADDR `bus_addr_ok` with `bus_wr=1` to the buffered word clears valid;
    - `rst` clears valid.
- **Undefined**: no buffer. Every fetch goes to the bus.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the FSM state enum;
  - `ADDR_W` and `DATA_W` defaults;
  - the all-ones instruction strobe constant.
- Sub-module `mem_arbiter_ibuf` exists only under `MEM_ARBITER_IBUF_EN`. It contains the buffer registers, hit compare and invalidate logic.
- The FSM, done flags and response latches stay in the top module.

## Test plan
- **Fetch only**: `inst_req=1`, `inst_addr=0xBFC00000`, slave gives `addr_ok` and `data_ok` in one cycle each returning `0x24080001`.
  - `bus_req` is high for exactly 1 cycle.
  - `stallreq_from_if` drops at cycle 3.
  - `inst_rdata=0x24080001`.
- **Simultaneous requests**: store to `0x80000010`, `data_sel=4'b0011`, `data_wdata=0x0000BEEF`, plus fetch `0xBFC00004`.
  - The store issues first with `bus_wstrb=0011`, then the fetch.
  - `stallreq_from_mem` falls before `stallreq_from_if`.
- **Slow slave**: `bus_addr_ok` delayed 3 cycles on a load from `0x80000020` returning `0x12345678`.
  - `bus_addr` is stable throughout.
  - `data_rdata=0x12345678`.
  - Held while `cpu_stall=1`.
- **Reset mid-transaction**: `rst` asserted in DATA_WAIT.
  - Next cycle: IDLE, `bus_req=0`, all outputs zero.
  - A stale `bus_data_ok` after reset changes nothing.
- **Done-flag hold**: `cpu_stall` held high 5 cycles after the fetch completes.
  - No re-issue of the fetch.
  - `stallreq_from_if` stays 0 until `cpu_stall=0`, then re-arms.
- **`MEM_ARBITER_IBUF_EN`**:
  - A repeat fetch of `0xBFC00000` hits with no `bus_req`.
  - A store to `0xBFC00000` invalidates the buffer; the next fetch goes to the bus.
